// File: rtl/coa_logic_pkg.sv
// Shared opcode and FSM state encodings for the bit-serial logic unit,
// plus the parity helper used when the result flags are built in.
package coa_logic_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Even-parity bit of a word zero-extended to 32 bits.
    function automatic logic even_parity32(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_logic_cell.sv
// One-bit logic cell: applies the selected AND/OR/XOR/NOR to a single bit pair.
module bit_logic_cell
    import coa_logic_pkg::*;
(
    input  logic       in1,
    input  logic       in2,
    input  logic [1:0] op,
    output logic       out
);

    // Opcode mux; every 2-bit code is a real operation.
    always_comb begin
        out = 1'b0;
        case (op)
            OP_AND:  out = in1 & in2;
            OP_OR:   out = in1 | in2;
            OP_XOR:  out = in1 ^ in2;
            OP_NOR:  out = ~(in1 | in2);
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_logic_unit.sv
// Bit-serial logic stage: evaluates a WIDTH-bit AND/OR/XOR/NOR one bit per cycle.
// Build option LOGIC_FLAGS_EN adds registered zero/parity flags of the result.
module bit_serial_logic_unit
    import coa_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [WIDTH-1:0] result
`ifdef LOGIC_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;
    logic             busy_nxt_s;

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [1:0]       sop_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;

    logic             bit_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] result_shift_s;

    bit_logic_cell u_cell (
        .in1 (sa_r[0]),
        .in2 (sb_r[0]),
        .op  (sop_r),
        .out (bit_s)
    );

    assign accept_s       = in_valid && in_ready_r;
    assign last_s         = (state_r == S_RUN) && (cnt_r == CNT_LAST);
    assign result_shift_s = {bit_s, result_r[WIDTH-1:1]};

    // State register with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Next-state decode: accept, serial run, then hold until the result is taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so the status outputs come straight from flops.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        case (state_nxt_s)
            S_IDLE: begin
                in_ready_nxt_s = 1'b1;
            end
            S_RUN: begin
                busy_nxt_s = 1'b1;
            end
            S_DONE: begin
                out_valid_nxt_s = 1'b1;
                busy_nxt_s      = 1'b1;
            end
            default: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // Operand shifters, bit counter and result assembly (LSB first, shifted in from the top).
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            sop_r    <= OP_AND;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            sa_r  <= a;
            sb_r  <= b;
            sop_r <= op;
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == S_RUN) begin
            sa_r     <= sa_r >> 1;
            sb_r     <= sb_r >> 1;
            result_r <= result_shift_s;
            // Counter parks on the last index instead of wrapping.
            cnt_r    <= last_s ? cnt_r : (cnt_r + CNT_ONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

`ifdef LOGIC_FLAGS_EN
    logic zero_r;
    logic parity_r;

    // Flags captured from the completed word on the RUN->DONE edge, cleared on a new accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_r   <= 1'b0;
            parity_r <= 1'b0;
        end else if (accept_s) begin
            zero_r   <= 1'b0;
            parity_r <= 1'b0;
        end else if (last_s) begin
            zero_r   <= (result_shift_s == {WIDTH{1'b0}});
            parity_r <= even_parity32(32'(result_shift_s));
        end
    end

    assign zero   = zero_r;
    assign parity = parity_r;
`endif

endmodule

// File: tb/tb_bit_serial_logic_unit.sv
// Self-checking bench for bit_serial_logic_unit: directed vectors with literal
// expectations plus a transaction-level model compared on every cycle.
module tb_bit_serial_logic_unit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       op = 2'b00;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [WIDTH-1:0] result;
`ifdef LOGIC_FLAGS_EN
    logic             zero;
    logic             parity;
`endif

    bit_serial_logic_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .result    (result)
`ifdef LOGIC_FLAGS_EN
        ,
        .zero      (zero),
        .parity    (parity)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [WIDTH-1:0] spec_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Transaction model: one op in flight, valid WIDTH edges after accept, retired on out_ready.
    bit               m_busy  = 1'b0;
    int               m_edges = 0;
    logic [WIDTH-1:0] m_exp   = '0;
    bit               m_clear = 1'b0;
    bit               cmp_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_edges <= 0;
            m_clear <= 1'b1;
            cmp_en  <= 1'b1;
        end else if (!m_busy) begin
            if (in_valid === 1'b1) begin
                m_busy  <= 1'b1;
                m_edges <= 0;
                m_exp   <= spec_op(a, b, op);
                m_clear <= 1'b0;
            end
        end else if (m_edges < WIDTH) begin
            m_edges <= m_edges + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_in_ready", 32'(in_ready), 32'(!m_busy));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_out_valid", 32'(out_valid), 32'(m_busy && (m_edges == WIDTH)));
            if (m_busy && (m_edges == WIDTH)) begin
                chk("m_result", 32'(result), 32'(m_exp));
`ifdef LOGIC_FLAGS_EN
                chk("m_zero", 32'(zero), 32'(m_exp == '0));
                chk("m_parity", 32'(parity), 32'(^m_exp));
`endif
            end
            if (m_clear) begin
                chk("m_result_clear", 32'(result), 32'h0);
`ifdef LOGIC_FLAGS_EN
                chk("m_flags_clear", {30'h0, zero, parity}, 32'h0);
`endif
            end
        end
    end

    task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic [1:0] ov);
        @(posedge clk); #1;
        in_valid = 1'b1; a = av; b = bv; op = ov;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic [1:0] ov, input logic [WIDTH-1:0] req, input int stall);
        out_ready = (stall == 0);
        accept(av, bv, ov);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            chk({name, "_early_valid"}, 32'(out_valid), 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'h1);
        chk({name, "_result"}, 32'(result), 32'(req));
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                in_valid = 1'b1; a = ~av; b = 8'h00; op = 2'b11;
                @(negedge clk);
                chk({name, "_stall_valid"}, 32'(out_valid), 32'h1);
                chk({name, "_stall_ready"}, 32'(in_ready), 32'h0);
                chk({name, "_stall_result"}, 32'(result), 32'(req));
            end
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_valid_drop"}, 32'(out_valid), 32'h0);
        chk({name, "_ready_back"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        in_valid  = 1'bx;
        out_ready = 1'bx;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_result", 32'(result), 32'h0);

        directed("and", 8'hF0, 8'h3C, 2'b00, 8'h30, 0);
        directed("nor", 8'h00, 8'h00, 2'b11, 8'hFF, 0);
        directed("or_stall", 8'hA5, 8'h5A, 2'b01, 8'hFF, 5);

        // Reset during the serial phase aborts the op.
        accept(8'hAA, 8'h0F, 2'b10);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        chk("abort_result", 32'(result), 32'h0);
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        directed("xor", 8'hAA, 8'h0F, 2'b10, 8'hA5, 0);

`ifdef LOGIC_FLAGS_EN
        directed("flag_zero", 8'h77, 8'h77, 2'b10, 8'h00, 0);
        chk("flag_zero_z", 32'(zero), 32'h1);
        chk("flag_zero_p", 32'(parity), 32'h0);
        directed("flag_par", 8'h01, 8'h00, 2'b01, 8'h01, 0);
        chk("flag_par_z", 32'(zero), 32'h0);
        chk("flag_par_p", 32'(parity), 32'h1);
`endif

        // Back-to-back random ops with random downstream backpressure.
        for (int i = 0; i < 20; i++) begin
            int budget;
            accept(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)));
            budget = 0;
            while (m_busy && budget < 200) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                budget++;
            end
            out_ready = 1'b0;
            if (budget >= 200) chk("rand_timeout", 32'(m_busy), 32'h0);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
